// File: rtl/cla_pipe_addsub_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor:
// operation encodings, lookahead group width and operand-prep helpers.
package cla_pipe_addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_ADC = 2'b01,
        OP_SUB = 2'b10,
        OP_SBB = 2'b11
    } op_e;

    localparam int GROUP_W = 4;

    // Subtraction is done as A + ~B + carry, so SUB/SBB invert the second operand.
    function automatic logic op_inverts_b(input op_e op);
        return (op == OP_SUB) || (op == OP_SBB);
    endfunction

    function automatic logic op_carry_in(input op_e op, input logic c_in);
        case (op)
            OP_ADD:  return 1'b0;
            OP_ADC:  return c_in;
            OP_SUB:  return 1'b1;
            default: return c_in;
        endcase
    endfunction

endpackage

// File: rtl/cla_pipe_addsub_stage.sv
// Combinational lookahead slice covering GPS 4-bit groups: group P/G, group
// carries from the incoming carry, then per-bit carries and sum.
module cla_pipe_addsub_stage
    import cla_pipe_addsub_pkg::*;
#(
    parameter int GPS = 2
) (
    input  logic [GROUP_W*GPS-1:0] a,
    input  logic [GROUP_W*GPS-1:0] b,
    input  logic                   cin,
    output logic [GROUP_W*GPS-1:0] sum,
    output logic                   cout,
    output logic                   c_into_top
);

    localparam int W = GROUP_W * GPS;

    logic [W-1:0]   p;
    logic [W-1:0]   g;
    logic [GPS-1:0] grp_p;
    logic [GPS-1:0] grp_g;
    logic [GPS:0]   grp_c;
    logic [W:0]     c;

    always_comb begin
        p     = a | b;
        g     = a & b;
        grp_p = '0;
        grp_g = '0;
        grp_c = '0;
        c     = '0;
        for (int j = 0; j < GPS; j++) begin
            grp_p[j] = &p[j*GROUP_W +: GROUP_W];
            grp_g[j] = g[j*GROUP_W+3]
                     | (p[j*GROUP_W+3] & g[j*GROUP_W+2])
                     | (p[j*GROUP_W+3] & p[j*GROUP_W+2] & g[j*GROUP_W+1])
                     | (p[j*GROUP_W+3] & p[j*GROUP_W+2] & p[j*GROUP_W+1] & g[j*GROUP_W]);
        end
        grp_c[0] = cin;
        for (int j = 0; j < GPS; j++) begin
            grp_c[j+1] = grp_g[j] | (grp_p[j] & grp_c[j]);
        end
        // Group boundaries take the lookahead carry; only the inner bits ripple locally.
        for (int j = 0; j < GPS; j++) begin
            c[j*GROUP_W] = grp_c[j];
            for (int i = 0; i < GROUP_W-1; i++) begin
                c[j*GROUP_W+i+1] = g[j*GROUP_W+i] | (p[j*GROUP_W+i] & c[j*GROUP_W+i]);
            end
        end
        c[W]       = grp_c[GPS];
        sum        = a ^ b ^ c[W-1:0];
        cout       = c[W];
        c_into_top = c[W-1];
    end

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead ADD/ADC/SUB/SBB with valid/ready flow control;
// each stage resolves one slice and forwards its carry and remaining operand bits.
module cla_pipe_addsub
    import cla_pipe_addsub_pkg::*;
#(
    parameter int N   = 16,
    parameter int GPS = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic         cIn,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic         cOut,
    output logic         ofl,
    output logic         zero
);

    localparam int SW = GROUP_W * GPS;
    localparam int S  = N / SW;

    logic [N-1:0]  b_prep;
    logic          cin_prep;
    logic [S-1:0]  v;
    logic [S-1:0]  load;

    logic [N-1:0]  a_src [S];
    logic [N-1:0]  b_src [S];
    logic [N-1:0]  s_src [S];
    logic          c_src [S];
    logic          v_src [S];

    logic [SW-1:0] slice_sum  [S];
    logic          slice_cout [S];
    logic          slice_ctop [S];

    logic [N-1:0]  a_r [S];
    logic [N-1:0]  b_r [S];
    logic [N-1:0]  s_r [S];
    logic          c_r [S];
    logic          cm_r;
    logic          zero_r;

    function automatic logic [N-1:0] merge_slice(input logic [N-1:0] base,
                                                 input logic [SW-1:0] sl,
                                                 input int k);
        merge_slice = base;
        merge_slice[k*SW +: SW] = sl;
    endfunction

    always_comb begin
        b_prep   = op_inverts_b(op_e'(op)) ? ~in2 : in2;
        cin_prep = op_carry_in(op_e'(op), cIn);
    end

    // Load enables ripple back from the output so a full pipe can still accept while draining.
    always_comb begin
        load = '0;
        load[S-1] = ~v[S-1] | out_ready;
        for (int k = S-2; k >= 0; k--) begin
            load[k] = ~v[k] | load[k+1];
        end
    end

    for (genvar k = 0; k < S; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign a_src[k] = in1;
            assign b_src[k] = b_prep;
            assign s_src[k] = '0;
            assign c_src[k] = cin_prep;
            assign v_src[k] = in_valid;
        end else begin : g_next
            assign a_src[k] = a_r[k-1];
            assign b_src[k] = b_r[k-1];
            assign s_src[k] = s_r[k-1];
            assign c_src[k] = c_r[k-1];
            assign v_src[k] = v[k-1];
        end

        cla_pipe_addsub_stage #(.GPS(GPS)) u_stage (
            .a          (a_src[k][k*SW +: SW]),
            .b          (b_src[k][k*SW +: SW]),
            .cin        (c_src[k]),
            .sum        (slice_sum[k]),
            .cout       (slice_cout[k]),
            .c_into_top (slice_ctop[k])
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v[k]   <= 1'b0;
                s_r[k] <= '0;
                c_r[k] <= 1'b0;
            end else if (load[k]) begin
                v[k]   <= v_src[k];
                s_r[k] <= merge_slice(s_src[k], slice_sum[k], k);
                c_r[k] <= slice_cout[k];
            end
        end

        if (k < S-1) begin : g_fwd
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_r[k] <= '0;
                    b_r[k] <= '0;
                end else if (load[k]) begin
                    a_r[k] <= a_src[k];
                    b_r[k] <= b_src[k];
                end
            end
        end else begin : g_last
            // Zero is computed from the finished sum here so it never lags the result.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cm_r   <= 1'b0;
                    zero_r <= 1'b0;
                end else if (load[k]) begin
                    cm_r   <= slice_ctop[k];
                    zero_r <= ~|merge_slice(s_src[k], slice_sum[k], k);
                end
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = v[S-1];
    assign out       = s_r[S-1];
    assign cOut      = c_r[S-1];
    assign ofl       = cm_r ^ c_r[S-1];
    assign zero      = zero_r;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed self-checking bench for cla_pipe_addsub (N=16, GPS=2, two stages).
module tb_cla_pipe_addsub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [15:0] in1;
    logic [15:0] in2;
    logic        cIn;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        cOut;
    logic        ofl;
    logic        zero;

    int testCount = 0;
    int failCount = 0;

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] ADC = 2'b01;
    localparam logic [1:0] SUB = 2'b10;
    localparam logic [1:0] SBB = 2'b11;

    logic [15:0] burstA   [8];
    logic [15:0] burstExp [8];

    cla_pipe_addsub #(.N(16), .GPS(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .cIn       (cIn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .cOut      (cOut),
        .ofl       (ofl),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [1:0] o, input logic [15:0] a,
                                 input logic [15:0] b, input logic c, input logic v);
        op       = o;
        in1      = a;
        in2      = b;
        cIn      = c;
        in_valid = v;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One isolated op: idle after the accepting edge, valid after the second edge.
    task automatic runSingle(input string tag, input logic [1:0] o, input logic [15:0] a,
                             input logic [15:0] b, input logic c, input logic [15:0] expOut,
                             input logic expC, input logic expOfl, input logic expZero);
        @(negedge clk);
        applyStimulus(o, a, b, c, 1'b1);
        #1 checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput({tag, " early valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput({tag, " out_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, " out"}, 32'(out), 32'(expOut));
        checkOutput({tag, " cOut"}, 32'(cOut), 32'(expC));
        checkOutput({tag, " ofl"}, 32'(ofl), 32'(expOfl));
        checkOutput({tag, " zero"}, 32'(zero), 32'(expZero));
    endtask

    initial begin
        burstA   = '{16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777};
        burstExp = '{16'h0001, 16'h1112, 16'h2223, 16'h3334, 16'h4445, 16'h5556, 16'h6667, 16'h7778};

        rst_n     = 1'b0;
        out_ready = 1'b1;
        applyStimulus(ADD, 16'h0000, 16'h0000, 1'b0, 1'b0);

        #12;
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset out", 32'(out), 32'd0);
        checkOutput("reset flags", {29'd0, cOut, ofl, zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 checkOutput("post-reset in_ready", 32'(in_ready), 32'd1);

        runSingle("add ovf",  ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        runSingle("adc wrap", ADC, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        runSingle("sub borrow", SUB, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        runSingle("sub equal", SUB, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        runSingle("sub ovf",  SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        runSingle("sbb borrowin", SBB, 16'h0005, 16'h0003, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0);
        runSingle("add ignores cIn", ADD, 16'h0001, 16'h0001, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
        runSingle("group carry", ADD, 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);

        $display("[TB] back-to-back burst");
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                checkOutput($sformatf("burst valid %0d", c-2), 32'(out_valid), 32'd1);
                checkOutput($sformatf("burst out %0d", c-2), 32'(out), 32'(burstExp[c-2]));
            end
            if (c < 8) begin
                applyStimulus(ADD, burstA[c], 16'h0001, 1'b0, 1'b1);
                #1 checkOutput($sformatf("burst in_ready %0d", c), 32'(in_ready), 32'd1);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        checkOutput("burst drained", 32'(out_valid), 32'd0);

        $display("[TB] stall");
        @(negedge clk);
        out_ready = 1'b0;
        applyStimulus(ADD, 16'h0100, 16'h0001, 1'b0, 1'b1);
        #1 checkOutput("stall accept A", 32'(in_ready), 32'd1);
        @(negedge clk);
        applyStimulus(ADD, 16'h0200, 16'h0002, 1'b0, 1'b1);
        #1 checkOutput("stall accept B", 32'(in_ready), 32'd1);
        @(negedge clk);
        applyStimulus(ADD, 16'h0300, 16'h0003, 1'b0, 1'b1);
        #1 checkOutput("stall full in_ready", 32'(in_ready), 32'd0);
        checkOutput("stall out A", {15'd0, out_valid, out}, {15'd0, 1'b1, 16'h0101});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("stall hold %0d", i), {14'd0, in_ready, out_valid, out},
                        {14'd0, 1'b0, 1'b1, 16'h0101});
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1 checkOutput("release in_ready", 32'(in_ready), 32'd1);
        checkOutput("release out A", {15'd0, out_valid, out}, {15'd0, 1'b1, 16'h0101});
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("release out B", {15'd0, out_valid, out}, {15'd0, 1'b1, 16'h0202});
        @(negedge clk);
        checkOutput("release out C", {15'd0, out_valid, out}, {15'd0, 1'b1, 16'h0303});
        @(negedge clk);
        checkOutput("release empty", 32'(out_valid), 32'd0);

        $display("[TB] reset mid-flight");
        @(negedge clk);
        applyStimulus(ADD, 16'h1111, 16'h1111, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(ADD, 16'h0001, 16'h1111, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("inflight first out", {15'd0, out_valid, out}, {15'd0, 1'b1, 16'h2222});
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset valid", 32'(out_valid), 32'd0);
        checkOutput("async reset out", 32'(out), 32'd0);
        checkOutput("async reset flags", {29'd0, cOut, ofl, zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("no ghost %0d", i), 32'(out_valid), 32'd0);
        end
        runSingle("after reset", ADD, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
